// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller for an external 16x8 true dual-port RAM.
// Port 0 is the write side and port 1 is the read side.
module dpram_fifo_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_req,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             rd_busy,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow,
  output logic [AW-1:0]    ram_ad_0,
  output logic             ram_we_0,
  output logic             ram_re_0,
  output logic [WIDTH-1:0] ram_wdata,
  output logic             ram_wdrive,
  output logic [AW-1:0]    ram_ad_1,
  output logic             ram_we_1,
  output logic             ram_re_1,
  input  logic [WIDTH-1:0] ram_rdata
);

  localparam int unsigned DEPTH = 2 ** AW;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t        state, next_state;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count_next;
  logic          push_ok, pop_ok;

  // Port 0 and port 1 are used in one direction only.
  assign ram_re_0 = 1'b0;
  assign ram_we_1 = 1'b0;

  assign push_ok = wr_en && !full;
  assign pop_ok  = (state == IDLE) && rd_req && !empty;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (pop_ok) next_state = ADDR;
      ADDR:    next_state = DATA;
      DATA:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    count_next = count;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count + (AW+1)'(1);
      2'b01:   count_next = count - (AW+1)'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      rd_busy    <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      ram_ad_0   <= '0;
      ram_we_0   <= 1'b0;
      ram_wdata  <= '0;
      ram_wdrive <= 1'b0;
      ram_ad_1   <= '0;
      ram_re_1   <= 1'b0;
    end else begin
      ram_we_0   <= push_ok;
      ram_wdrive <= push_ok;
      if (push_ok) begin
        ram_ad_0  <= wr_ptr;
        ram_wdata <= wr_data;
        wr_ptr    <= wr_ptr + AW'(1);
      end
      overflow  <= wr_en && full;
      underflow <= (state == IDLE) && rd_req && empty;

      if (pop_ok) begin
        ram_ad_1 <= rd_ptr;
        rd_ptr   <= rd_ptr + AW'(1);
      end
      // Strobe covers ADDR (RAM loads its read register) and DATA (word on bus).
      ram_re_1 <= (next_state != IDLE);
      rd_busy  <= (next_state != IDLE);

      rd_valid <= (state == DATA);
      if (state == DATA) rd_data <= ram_rdata;

      count <= count_next;
      full  <= (count_next == (AW+1)'(DEPTH));
      empty <= (count_next == '0);
    end
  end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Directed bench for dpram_fifo_ctrl with a behavioural dual-port RAM:
// port 0 writes on the falling edge, port 1 loads its read register on the rising edge.
module tb_dpram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst, wr_en, rd_req;
  logic [7:0] wr_data, rd_data, ram_wdata, ram_rdata;
  logic       rd_valid, rd_busy, full, empty, overflow, underflow;
  logic [4:0] count;
  logic [3:0] ram_ad_0, ram_ad_1;
  logic       ram_we_0, ram_re_0, ram_wdrive, ram_we_1, ram_re_1;

  logic [7:0] mem [16];
  logic [7:0] rd_reg = 8'h00;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [3:0]  wp, rp;

  dpram_fifo_ctrl #(.WIDTH(8), .AW(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_req(rd_req),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_busy(rd_busy), .full(full),
    .empty(empty), .count(count), .overflow(overflow), .underflow(underflow),
    .ram_ad_0(ram_ad_0), .ram_we_0(ram_we_0), .ram_re_0(ram_re_0),
    .ram_wdata(ram_wdata), .ram_wdrive(ram_wdrive), .ram_ad_1(ram_ad_1),
    .ram_we_1(ram_we_1), .ram_re_1(ram_re_1), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (ram_we_0 && ram_wdrive) mem[ram_ad_0] <= ram_wdata;
  always @(posedge clk) if (ram_re_1) rd_reg <= mem[ram_ad_1];
  assign ram_rdata = rd_reg;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d;
    step();
    wr_en = 1'b0;
    check("push_we0", ram_we_0, 1);
    check("push_wdrive", ram_wdrive, 1);
    check("push_ad0", ram_ad_0, wp);
    check("push_wdata", ram_wdata, d);
    wp = wp + 4'd1;
  endtask

  // Accept a pop at the end of the current cycle and follow it to rd_valid.
  task automatic pop(input logic [7:0] d);
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    check("pop_re1_c1", ram_re_1, 1);
    check("pop_ad1_c1", ram_ad_1, rp);
    check("pop_busy_c1", rd_busy, 1);
    check("pop_valid_c1", rd_valid, 0);
    step();
    check("pop_re1_c2", ram_re_1, 1);
    check("pop_ad1_c2", ram_ad_1, rp);
    check("pop_valid_c2", rd_valid, 0);
    step();
    check("pop_valid_c3", rd_valid, 1);
    check("pop_data", rd_data, d);
    check("pop_re1_c3", ram_re_1, 0);
    check("pop_busy_c3", rd_busy, 0);
    rp = rp + 4'd1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"}, count, 0);
    check({tag, "_empty"}, empty, 1);
    check({tag, "_full"}, full, 0);
    check({tag, "_valid"}, rd_valid, 0);
    check({tag, "_busy"}, rd_busy, 0);
    check({tag, "_rdata"}, rd_data, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_unf"}, underflow, 0);
    check({tag, "_ram"}, {ram_ad_0, ram_we_0, ram_re_0, ram_wdata, ram_wdrive,
                          ram_ad_1, ram_we_1, ram_re_1}, 0);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_req = 1'b0; wr_data = 8'h00;
    wp = 4'd0; rp = 4'd0;
    step(); step();
    check_reset_state("rst");
    rst = 1'b0;
    step();

    // Single word round trip.
    push(8'hA5);
    check("one_count", count, 1);
    check("one_empty", empty, 0);
    step();
    check("one_we0_off", ram_we_0, 0);
    pop(8'hA5);
    check("one_empty_after", empty, 1);
    step();
    check("one_valid_pulse", rd_valid, 0);
    check("one_rdata_hold", rd_data, 8'hA5);

    // Fill, overflow, drain (pointers start at 1, so addresses wrap).
    for (int i = 0; i < 16; i++) push(8'(i));
    check("fill_full", full, 1);
    check("fill_count", count, 16);
    wr_en = 1'b1; wr_data = 8'hEE;
    step();
    wr_en = 1'b0;
    check("ovf_pulse", overflow, 1);
    check("ovf_no_we", ram_we_0, 0);
    check("ovf_count", count, 16);
    step();
    check("ovf_one_cycle", overflow, 0);
    for (int i = 0; i < 16; i++) pop(8'(i));
    check("drain_empty", empty, 1);

    // 20 words across the wrap boundary.
    for (int i = 0; i < 10; i++) push(8'h40 + 8'(i));
    step();
    for (int i = 0; i < 10; i++) pop(8'h40 + 8'(i));
    for (int i = 10; i < 20; i++) push(8'h40 + 8'(i));
    step();
    for (int i = 10; i < 20; i++) pop(8'h40 + 8'(i));
    check("wrap_empty", empty, 1);

    // Simultaneous push and pop acceptance at count 3; rd_req during ADDR ignored.
    push(8'h11); push(8'h22); push(8'h33);
    check("sim_count3", count, 3);
    wr_en = 1'b1; wr_data = 8'h44; rd_req = 1'b1;
    step();
    wr_en = 1'b0;
    check("sim_count", count, 3);
    check("sim_we0", ram_we_0, 1);
    check("sim_ad0", ram_ad_0, wp);
    check("sim_re1", ram_re_1, 1);
    check("sim_ad1", ram_ad_1, rp);
    wp = wp + 4'd1;
    step();
    rd_req = 1'b0;
    check("addr_req_unf", underflow, 0);
    check("addr_req_count", count, 3);
    check("addr_req_ad1", ram_ad_1, rp);
    step();
    check("sim_valid", rd_valid, 1);
    check("sim_data", rd_data, 8'h11);
    check("sim_busy_off", rd_busy, 0);
    rp = rp + 4'd1;
    pop(8'h22); pop(8'h33); pop(8'h44);
    check("sim_empty", empty, 1);

    // Pop while empty.
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    check("unf_pulse", underflow, 1);
    check("unf_no_re1", ram_re_1, 0);
    check("unf_no_busy", rd_busy, 0);
    step();
    check("unf_one_cycle", underflow, 0);
    check("unf_no_valid", rd_valid, 0);

    // Reset while the FSM is in DATA.
    push(8'h3C);
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    step();
    check("abort_in_data", ram_re_1, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_state("abort");
    step();
    check("abort_no_valid", rd_valid, 0);
    check("abort_rdata", rd_data, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dpram_fifo_ctrl.md
DPRAM_FIFO_CTRL -- requirements
Module: dpram_fifo_ctrl

Interface
REQ-001 Parameters SHALL be: WIDTH, default 8, data word width; AW, default 4, RAM address width; DEPTH, fixed at 2**AW (16), RAM word count.
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  single clock; all registers update on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  push request
- wr_data  in  WIDTH  push word
- rd_req  in  1  pop request
- rd_data  out  WIDTH  popped word
- rd_valid  out  1  one-cycle pulse; rd_data valid
- rd_busy  out  1  read sequence in progress
- full  out  1  count==DEPTH
- empty  out  1  count==0
- count  out  AW+1  stored word count
- overflow  out  1  one-cycle pulse; push refused
- underflow  out  1  one-cycle pulse; pop refused
- ram_ad_0  out  AW  RAM port-0 address (write side)
- ram_we_0  out  1  RAM port-0 write enable
- ram_re_0  out  1  RAM port-0 read enable; constant 0
- ram_wdata  out  WIDTH  word to drive onto RAM port-0 data bus
- ram_wdrive  out  1  bus-drive enable for ram_wdata; equals ram_we_0
- ram_ad_1  out  AW  RAM port-1 address (read side)
- ram_we_1  out  1  RAM port-1 write enable; constant 0
- ram_re_1  out  1  RAM port-1 read enable
- ram_rdata  in  WIDTH  RAM port-1 data bus
REQ-003 Clock SHALL be clk; reset SHALL be rst, synchronous, active-high.
REQ-004 All outputs SHALL be registered.

Function
REQ-005 The block SHALL be a FIFO controller driving a 16x8 true dual-port RAM; port 0 writes at falling edge, port 1 loads its read register at rising edge.
REQ-006 Push is accepted when wr_en=1 and full=0 at a rising edge; in the next cycle ram_we_0=ram_wdrive=1 for exactly one cycle, with ram_ad_0=wr_ptr and ram_wdata=wr_data; wr_ptr increments.
REQ-007 wr_en=1 with full=1 SHALL be ignored (no RAM strobe, no pointer change) and SHALL pulse overflow in the next cycle.
REQ-008 Read FSM states SHALL be: IDLE -> ADDR -> DATA -> IDLE.
REQ-009 In IDLE, rd_req=1 with empty=0 SHALL be accepted: next state ADDR, ram_ad_1=rd_ptr, rd_ptr increments.
REQ-010 In ADDR and DATA, ram_re_1=1, ram_ad_1 SHALL be held, and rd_busy=1.
REQ-011 At the rising edge ending DATA, ram_rdata SHALL be captured into rd_data; rd_valid=1 for the following cycle only.
REQ-012 Read latency: acceptance edge at end of cycle 0; ram_re_1 high in cycles 1-2; rd_valid in cycle 3.
REQ-013 rd_req in IDLE with empty=1 SHALL pulse underflow in the next cycle; rd_req outside IDLE SHALL be ignored without underflow.
REQ-014 count SHALL increment on an accepted push, decrement on an accepted pop, and stay unchanged when both occur at the same edge.
REQ-015 full and empty SHALL be derived from the updated count in the same edge.
REQ-016 Pointers SHALL be AW bits and wrap from 15 to 0.
REQ-017 A word whose push was accepted in cycle N SHALL be readable by a pop accepted at the end of cycle N+1 or later. The falling-edge write in cycle N+1 precedes the port-1 load at the end of cycle N+2.
REQ-018 rd_data SHALL hold its last value between pulses.

Reset
REQ-019 With rst=1 at a rising edge, these SHALL be set: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, FSM=IDLE, rd_busy=0, rd_valid=0, rd_data=0, overflow=0, underflow=0, all ram_* outputs=0.
REQ-020 Reset SHALL take priority over wr_en and rd_req in the same cycle.
REQ-021 Reset during ADDR or DATA SHALL abort the read; no rd_valid pulse SHALL follow.
REQ-022 RAM contents are not cleared by reset.

Verification
REQ-023 Reset, then push 0xA5 -> count=1, empty=0; pop -> ram_re_1 high for two cycles at ad 0; rd_data=0xA5 with rd_valid one cycle; then empty=1.
REQ-024 Push 16 words 0x00..0x0F -> full=1, count=16; a 17th push -> overflow pulse, count stays 16; pop all 16 -> data 0x00..0x0F in order.
REQ-025 Push and pop across the wrap boundary (20 words) -> ram_ad_0 and ram_ad_1 both wrap 15->0; data order preserved.
REQ-026 With count=3, push accepted at the same edge as pop acceptance -> count stays 3; rd_req during ADDR is ignored, no underflow.
REQ-027 rd_req while empty -> underflow pulse, no ram_re_1.
REQ-028 Assert rst during DATA -> no rd_valid, all outputs at their reset values the next cycle.
